// File: rtl/vram_read_arbiter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vram_read_arbiter_if : scanner, client and BRAM read-port bundle  (rev 1.0)
// -----------------------------------------------------------------------------
interface vram_read_arbiter_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_CLIENTS = 2
);
  logic                              video_rd_i;
  logic [ADDR_WIDTH-1:0]             video_addr_i;
  logic [31:0]                       video_data_o;
  logic                              video_valid_o;
  logic [NUM_CLIENTS-1:0]            client_req_i;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr_i;
  logic [NUM_CLIENTS-1:0]            client_gnt_o;
  logic [NUM_CLIENTS-1:0]            client_valid_o;
  logic [31:0]                       client_data_o;
  logic [NUM_CLIENTS-1:0]            client_starve_o;
  logic                              mem_rd_o;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic [31:0]                       mem_data_i;

  modport slave (
    input  video_rd_i, video_addr_i, client_req_i, client_addr_i, mem_data_i,
    output video_data_o, video_valid_o, client_gnt_o, client_valid_o,
           client_data_o, client_starve_o, mem_rd_o, mem_addr_o
  );

  modport master (
    output video_rd_i, video_addr_i, client_req_i, client_addr_i, mem_data_i,
    input  video_data_o, video_valid_o, client_gnt_o, client_valid_o,
           client_data_o, client_starve_o, mem_rd_o, mem_addr_o
  );
endinterface
`default_nettype wire

// File: rtl/vram_read_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vram_read_arbiter : video-priority / round-robin sharing of one BRAM read port  (rev 1.0)
// -----------------------------------------------------------------------------
module vram_read_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_CLIENTS  = 2,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk_logic,
  input  logic               system_reset,
  vram_read_arbiter_if.slave bus
);
  localparam int c_IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int c_CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CLIENTS - 1);

  typedef struct packed {
    logic               valid;
    logic               is_video;
    logic [c_IDX_W-1:0] idx;
  } tag_t;

  logic [NUM_CLIENTS-1:0] w_eligible;
  logic                   w_lo_any;
  logic                   w_hi_any;
  logic [c_IDX_W-1:0]     w_lo_sel;
  logic [c_IDX_W-1:0]     w_hi_sel;
  logic                   w_client_any;
  logic [c_IDX_W-1:0]     w_client_sel;
  logic [c_IDX_W-1:0]     w_ptr_nxt;
  logic [ADDR_WIDTH-1:0]  w_client_addr;
  logic [NUM_CLIENTS-1:0] w_starve_nxt;
  tag_t                   w_ret;

  logic [c_IDX_W-1:0]     r_rr_ptr;
  logic                   r_mem_rd;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic                   r_iss_video;
  logic [c_IDX_W-1:0]     r_iss_idx;
  logic [NUM_CLIENTS-1:0] r_gnt;
  tag_t                   r_tag [READ_LATENCY];
  logic                   r_vvalid;
  logic [31:0]            r_vdata;
  logic [NUM_CLIENTS-1:0] r_cvalid;
  logic [31:0]            r_cdata;
  logic [NUM_CLIENTS-1:0] r_starve;

  // A client whose grant is showing this cycle is still holding its old request.
  assign w_eligible = bus.client_req_i & ~r_gnt;

  always_comb begin
    w_lo_any = 1'b0;
    w_hi_any = 1'b0;
    w_lo_sel = '0;
    w_hi_sel = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (w_eligible[k]) begin
        w_lo_any = 1'b1;
        w_lo_sel = c_IDX_W'(k);
        if (k >= int'(r_rr_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_sel = c_IDX_W'(k);
        end
      end
    end
  end

  assign w_client_any  = w_lo_any;
  assign w_client_sel  = w_hi_any ? w_hi_sel : w_lo_sel;
  assign w_ptr_nxt     = (w_client_sel == c_LAST_IDX) ? '0 : w_client_sel + c_IDX_W'(1);
  assign w_client_addr = bus.client_addr_i[int'(w_client_sel)*ADDR_WIDTH +: ADDR_WIDTH];

  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      r_rr_ptr    <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_iss_video <= 1'b0;
      r_iss_idx   <= '0;
      r_gnt       <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      r_gnt    <= '0;
      if (bus.video_rd_i) begin
        r_mem_rd    <= 1'b1;
        r_mem_addr  <= bus.video_addr_i;
        r_iss_video <= 1'b1;
      end else if (w_client_any) begin
        r_mem_rd            <= 1'b1;
        r_mem_addr          <= w_client_addr;
        r_iss_video         <= 1'b0;
        r_iss_idx           <= w_client_sel;
        r_gnt[w_client_sel] <= 1'b1;
        r_rr_ptr            <= w_ptr_nxt;
      end
    end
  end

  // Tag stage 0 lines up with the cycle after the BRAM sees mem_rd_o.
  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      for (int i = 0; i < READ_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: r_mem_rd, is_video: r_iss_video, idx: r_iss_idx};
      for (int i = 1; i < READ_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_ret = r_tag[READ_LATENCY-1];

  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      r_vvalid <= 1'b0;
      r_vdata  <= '0;
      r_cvalid <= '0;
      r_cdata  <= '0;
      r_starve <= '0;
    end else begin
      r_vvalid <= w_ret.valid & w_ret.is_video;
      r_cvalid <= '0;
      r_starve <= w_starve_nxt;
      if (w_ret.valid && w_ret.is_video) begin
        r_vdata <= bus.mem_data_i;
      end
      if (w_ret.valid && !w_ret.is_video) begin
        r_cvalid[w_ret.idx] <= 1'b1;
        r_cdata             <= bus.mem_data_i;
      end
    end
  end

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_starve
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [c_CNT_W-1:0] w_wait_nxt;

    always_comb begin
      w_wait_nxt = '0;
      if (bus.client_req_i[k] && !r_gnt[k]) begin
        w_wait_nxt = (r_wait_cnt >= c_CNT_MAX) ? c_CNT_MAX : r_wait_cnt + c_CNT_W'(1);
      end
    end

    always_ff @(posedge clk_logic or posedge system_reset) begin
      if (system_reset) r_wait_cnt <= '0;
      else              r_wait_cnt <= w_wait_nxt;
    end

    assign w_starve_nxt[k] = (w_wait_nxt >= c_CNT_MAX);
  end

  assign bus.mem_rd_o        = r_mem_rd;
  assign bus.mem_addr_o      = r_mem_addr;
  assign bus.client_gnt_o    = r_gnt;
  assign bus.video_valid_o   = r_vvalid;
  assign bus.video_data_o    = r_vdata;
  assign bus.client_valid_o  = r_cvalid;
  assign bus.client_data_o   = r_cdata;
  assign bus.client_starve_o = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_vram_read_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_vram_read_arbiter : directed + random stimulus against a timeline model  (rev 1.0)
// -----------------------------------------------------------------------------
module tb_vram_read_arbiter;
  localparam int AW    = 12;
  localparam int NC    = 2;
  localparam int RL    = 1;
  localparam int LIMIT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_read_arbiter_if #(.ADDR_WIDTH(AW), .NUM_CLIENTS(NC)) bus ();

  vram_read_arbiter #(
    .ADDR_WIDTH(AW), .NUM_CLIENTS(NC), .READ_LATENCY(RL), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_logic    (clk),
    .system_reset (rst),
    .bus          (bus)
  );

  function automatic logic [31:0] bram_word(input logic [AW-1:0] a);
    return 32'(a) * 32'h01010101;
  endfunction

  // BRAM: word = addr * 0x01010101, returned RL cycles after the read enable.
  logic [31:0] bram_pipe [RL];
  always @(posedge clk) begin
    if (bus.mem_rd_o) bram_pipe[0] <= bram_word(bus.mem_addr_o);
    for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bus.mem_data_i = bram_pipe[RL-1];

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: each accepted read schedules its return at decision cycle + RL + 2.
  typedef struct {
    int          due;
    bit          vid;
    int          k;
    logic [31:0] d;
  } ret_t;

  ret_t            rq[$];
  ret_t            m_r;
  int              cyc = 0;
  int              m_ptr;
  int              m_win;
  int              m_k;
  int              m_wait [NC];
  logic [AW-1:0]   m_a;
  logic            e_rd, e_vvalid;
  logic [AW-1:0]   e_addr;
  logic [NC-1:0]   e_gnt, e_cvalid, e_starve;
  logic [31:0]     e_vdata, e_cdata;

  always @(posedge clk) begin
    if (rst) begin
      e_rd = 0; e_addr = '0; e_gnt = '0; e_vvalid = 0; e_vdata = '0;
      e_cvalid = '0; e_cdata = '0; e_starve = '0; m_ptr = 0;
      for (int k = 0; k < NC; k++) m_wait[k] = 0;
      rq.delete();
    end else begin
      m_win = -1;
      if (!bus.video_rd_i) begin
        for (int i = 0; i < NC; i++) begin
          m_k = (m_ptr + i) % NC;
          if (m_win < 0 && bus.client_req_i[m_k] && !e_gnt[m_k]) m_win = m_k;
        end
      end
      for (int k = 0; k < NC; k++) begin
        if (bus.client_req_i[k] && !e_gnt[k]) m_wait[k] = (m_wait[k] < LIMIT) ? m_wait[k] + 1 : LIMIT;
        else m_wait[k] = 0;
        e_starve[k] = (m_wait[k] >= LIMIT);
      end
      e_gnt = '0;
      e_rd  = bus.video_rd_i || (m_win >= 0);
      if (bus.video_rd_i) begin
        e_addr = bus.video_addr_i;
        rq.push_back('{cyc + RL + 2, 1'b1, 0, bram_word(bus.video_addr_i)});
      end else if (m_win >= 0) begin
        m_a = bus.client_addr_i[m_win*AW +: AW];
        e_addr = m_a;
        e_gnt[m_win] = 1'b1;
        m_ptr = (m_win + 1) % NC;
        rq.push_back('{cyc + RL + 2, 1'b0, m_win, bram_word(m_a)});
      end
      e_vvalid = 0;
      e_cvalid = '0;
      if (rq.size() > 0 && rq[0].due == cyc + 1) begin
        m_r = rq.pop_front();
        if (m_r.vid) begin e_vvalid = 1; e_vdata = m_r.d; end
        else begin e_cvalid[m_r.k] = 1'b1; e_cdata = m_r.d; end
      end
    end
    cyc++;
  end

  int n_vvalid = 0;
  int n_gnt    = 0;
  int n_cvalid = 0;

  always @(negedge clk) begin
    chk("mem_rd",   32'(bus.mem_rd_o),        rst ? 32'd0 : 32'(e_rd));
    chk("mem_addr", 32'(bus.mem_addr_o),      rst ? 32'd0 : 32'(e_addr));
    chk("gnt",      32'(bus.client_gnt_o),    rst ? 32'd0 : 32'(e_gnt));
    chk("vvalid",   32'(bus.video_valid_o),   rst ? 32'd0 : 32'(e_vvalid));
    chk("vdata",    bus.video_data_o,         rst ? 32'd0 : e_vdata);
    chk("cvalid",   32'(bus.client_valid_o),  rst ? 32'd0 : 32'(e_cvalid));
    chk("cdata",    bus.client_data_o,        rst ? 32'd0 : e_cdata);
    chk("starve",   32'(bus.client_starve_o), rst ? 32'd0 : 32'(e_starve));
    if (bus.video_valid_o === 1'b1) n_vvalid++;
    n_gnt    += $countones(bus.client_gnt_o);
    n_cvalid += $countones(bus.client_valid_o);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  bit seen [NC];

  task automatic drive_clients_random();
    for (int k = 0; k < NC; k++) begin
      if (bus.client_gnt_o[k]) begin
        seen[k] = 1;
      end else if (seen[k] || !bus.client_req_i[k]) begin
        seen[k] = 0;
        bus.client_req_i[k] = ($urandom_range(0, 2) == 0);
        bus.client_addr_i[k*AW +: AW] = AW'($urandom_range(0, 4095));
      end else if ($urandom_range(0, 31) == 0) begin
        bus.client_req_i[k] = 1'b0;
      end
    end
  endtask

  int base;
  int base_c;
  logic [NC-1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    bus.video_rd_i    = 0;
    bus.video_addr_i  = '0;
    bus.client_req_i  = '0;
    bus.client_addr_i = '0;
    repeat (3) step();
    rst = 0;
    step();

    // Single video read: issue next cycle, data three cycles after the request.
    bus.video_rd_i = 1; bus.video_addr_i = 12'h0AB;
    step();
    bus.video_rd_i = 0;
    sample();
    chk("pin_issue_rd", 32'(bus.mem_rd_o), 32'd1);
    chk("pin_issue_addr", 32'(bus.mem_addr_o), 32'h0AB);
    step(); step();
    sample();
    chk("pin_vvalid", 32'(bus.video_valid_o), 32'd1);
    chk("pin_vdata", bus.video_data_o, 32'hABABABAB);

    // Back-to-back video sweep.
    step();
    base = n_vvalid;
    for (int a = 0; a < 16; a++) begin
      bus.video_rd_i = 1; bus.video_addr_i = AW'(a);
      step();
    end
    bus.video_rd_i = 0;
    repeat (4) step();
    chk("sweep_count", 32'(n_vvalid - base), 32'd16);
    chk("sweep_last", bus.video_data_o, 32'h0F0F0F0F);

    // Reset with reads in flight.
    for (int a = 0; a < 3; a++) begin
      bus.video_rd_i = 1; bus.video_addr_i = AW'(12'h020 + a);
      step();
    end
    rst = 1; bus.video_rd_i = 0;
    base = n_vvalid;
    step(); step();
    rst = 0;
    bus.video_rd_i = 1; bus.video_addr_i = 12'h077;
    step();
    bus.video_rd_i = 0;
    step();
    sample();
    chk("rst_no_stale", 32'(n_vvalid - base), 32'd0);
    step();
    sample();
    chk("rst_first_valid", 32'(bus.video_valid_o), 32'd1);
    chk("rst_first_data", bus.video_data_o, 32'h77777777);
    step();

    // Round-robin between two held requests.
    bus.client_req_i = 2'b11;
    bus.client_addr_i = {12'h200, 12'h100};
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      chk("rr_gnt", 32'(bus.client_gnt_o), 32'(rr_exp[i]));
      if (i == 2) chk("rr_cdata0", bus.client_data_o, 32'h01010100);
      if (i == 3) chk("rr_cdata1", bus.client_data_o, 32'h02020200);
    end
    bus.client_req_i = '0;
    repeat (4) step();

    // Starvation under continuous video.
    bus.client_addr_i = {12'h055, 12'h000};
    bus.client_req_i = 2'b10;
    bus.video_rd_i = 1;
    base = n_gnt;
    for (int i = 1; i <= 70; i++) begin
      bus.video_addr_i = AW'($urandom_range(0, 4095));
      step();
      if (i == 63) begin sample(); chk("starve_before", 32'(bus.client_starve_o), 32'd0); end
      if (i == 64) begin sample(); chk("starve_rise", 32'(bus.client_starve_o), 32'b10); end
    end
    chk("starve_no_gnt", 32'(n_gnt - base), 32'd0);
    bus.video_rd_i = 0;
    step();
    sample();
    chk("starve_gnt", 32'(bus.client_gnt_o), 32'b10);
    chk("starve_held", 32'(bus.client_starve_o), 32'b10);
    bus.client_req_i = '0;
    step();
    sample();
    chk("starve_clear", 32'(bus.client_starve_o), 32'd0);
    repeat (3) step();

    // Video toggling with client 0 re-requesting.
    bus.client_addr_i = {12'h000, 12'h3FF};
    bus.client_req_i = 2'b01;
    for (int i = 0; i < 12; i++) begin
      bus.video_rd_i = ((i % 2) == 0);
      bus.video_addr_i = AW'($urandom_range(0, 4095));
      step();
    end
    bus.video_rd_i = 0;
    bus.client_req_i = '0;
    repeat (4) step();

    // Withdrawn request during a video burst.
    base = n_gnt; base_c = n_cvalid;
    bus.video_rd_i = 1;
    for (int i = 0; i < 10; i++) begin
      bus.video_addr_i = AW'($urandom_range(0, 4095));
      bus.client_req_i = (i >= 2 && i < 6) ? 2'b01 : 2'b00;
      step();
    end
    bus.video_rd_i = 0;
    bus.client_req_i = '0;
    repeat (4) step();
    chk("withdraw_gnt", 32'(n_gnt - base), 32'd0);
    chk("withdraw_cvalid", 32'(n_cvalid - base_c), 32'd0);

    // Random traffic with one reset in the middle.
    for (int k = 0; k < NC; k++) seen[k] = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) rst = 1;
      if (i == 1202) rst = 0;
      bus.video_rd_i = ($urandom_range(0, 4) < 2);
      bus.video_addr_i = AW'($urandom_range(0, 4095));
      drive_clients_random();
      step();
    end
    bus.video_rd_i = 0;
    bus.client_req_i = '0;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_read_arbiter.md
Name: vram_read_arbiter

Overview:
- Shares the single 32-bit read port of a shadow-video BRAM bank (text / hires main / hires aux) between the video scanner and NUM_CLIENTS secondary readers (VGC fetch, debug/host readback).
- Video scanner has absolute priority; secondary clients are served round-robin in idle slots, with a request/grant handshake and tagged read-data return.
- Sits between the scanner/VGC logic and each sdpram32 read port; the write side of the BRAM is untouched.

Parameters:
ADDR_WIDTH, 12, BRAM word-address width
NUM_CLIENTS, 2, number of secondary requesters (1..4)
READ_LATENCY, 1, BRAM read latency in cycles (1..3)
STARVE_LIMIT, 64, wait cycles before a client's starve flag asserts

Ports:
clk_logic  in  1  logic clock
system_reset  in  1  asynchronous active-high reset
video_rd_i  in  1  scanner read request this cycle
video_addr_i  in  ADDR_WIDTH  scanner word address
video_data_o  out  32  scanner read data
video_valid_o  out  1  video_data_o valid pulse
client_req_i  in  NUM_CLIENTS  per-client read request (level)
client_addr_i  in  NUM_CLIENTS*ADDR_WIDTH  packed client addresses, client k at [k*ADDR_WIDTH +: ADDR_WIDTH]
client_gnt_o  out  NUM_CLIENTS  one-hot grant pulse
client_valid_o  out  NUM_CLIENTS  one-hot read-data-valid pulse
client_data_o  out  32  shared client read data
client_starve_o  out  NUM_CLIENTS  client waited >= STARVE_LIMIT cycles
mem_rd_o  out  1  BRAM read enable
mem_addr_o  out  ADDR_WIDTH  BRAM read address
mem_data_i  in  32  BRAM read data, READ_LATENCY cycles after mem_rd_o

Behaviour:
- Reset (async, active-high): all outputs 0; RR pointer = 0; tag pipeline cleared; wait counters = 0. Reads in flight at reset are discarded; no valid pulses follow reset.
- Arbitration in cycle t:
  - if video_rd_i: video wins;
  - else the eligible client with the lowest index at or after the RR pointer (wrapping) wins.
  - Eligible means client_req_i[k]=1 and client_gnt_o[k]=0 this cycle, so a held request is not double-granted.
- Issue, registered at t+1:
  - mem_rd_o = 1 and mem_addr_o = winner's address.
  - For a client winner, client_gnt_o[k] = 1 for exactly one cycle; RR pointer becomes k+1 mod NUM_CLIENTS.
  - No winner: mem_rd_o = 0; mem_addr_o holds its previous value.
- Return:
  - A tag pipeline of depth READ_LATENCY (fields: valid, is_video, client index) tracks each issue.
  - At t+1+READ_LATENCY, mem_data_i is registered into video_data_o (video) or client_data_o (client k), and the matching video_valid_o or client_valid_o[k] pulses for 1 cycle, aligned with the data.
  - Data outputs hold their last value otherwise.
  - Total latency: video 1+READ_LATENCY+1 register = READ_LATENCY+2 from video_rd_i; clients READ_LATENCY+1 from gnt. With READ_LATENCY=1: video_valid 3 cycles after video_rd_i; client_valid 2 cycles after gnt.
- Throughput: one read issued per cycle maximum; back-to-back issues are fully pipelined.
- Client handshake:
  - Client holds req and addr stable until it samples gnt.
  - In the cycle after gnt it may drop req, or keep it high with a new address for the next read.
  - Dropping req before gnt withdraws the request with no side effect.
- Starvation:
  - Per-client saturating counter increments each cycle req=1 without gnt; clears on gnt or req=0.
  - client_starve_o[k] = (counter >= STARVE_LIMIT), registered.
  - Status only; video priority is never overridden.
- Simultaneous events: video_rd_i together with any client request → video issued, clients wait with no pointer change. All clients requesting → strict rotation 0,1,…,N-1,0.

Test Plan:
- Reset mid-stream: video reads each cycle, assert system_reset for 2 cycles while 2 reads are in flight → all outputs 0, no video_valid after release; first new read at cycle r returns at r+3 (READ_LATENCY=1).
- Video-only sweep: video_rd_i=1 for addr 0x000..0x00F back-to-back, BRAM model data=addr*0x01010101 → 16 consecutive video_valid pulses with matching data, latency 3.
- Round-robin: video idle, both clients hold req, addresses 0x100/0x200 → gnt sequence 0,1,0,1 on alternate issue cycles; client_data matches 0x100/0x200 contents; no double grant.
- Priority/starvation: video_rd_i=1 for 70 cycles, client 1 req=1 → no client gnt, client_starve_o[1] rises after 64 cycles; video drops → gnt[1] next cycle, starve clears the cycle after.
- Interleave: video_rd_i toggles 1,0,1,0 with client 0 requesting addr 0x3FF → client issued only in video-idle slots; video and client data never swapped; tags correct.
- Withdraw: client 0 raises req during a video burst, drops it before grant → no gnt, no valid, counter back to 0.
